// File: rtl/pu_msp430_wakeup_pkg.sv
// pu_msp430_wakeup_pkg: shared types, limits and helpers for the wakeup gate.
//   wkup_state_t : FSM state encoding (IDLE / ASSERT / RELEASE)
//   *_MIN/*_MAX  : legal parameter ranges
//   idw_f()      : width of the winning-channel index, max(1, clog2(n))
package pu_msp430_wakeup_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ASSERT  = 2'd1,
      RELEASE = 2'd2
   } wkup_state_t;

   localparam int NCH_MIN  = 1;
   localparam int NCH_MAX  = 32;
   localparam int SYNC_MIN = 2;
   localparam int HOLD_MIN = 1;

   function automatic int idw_f(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/pu_msp430_sync_cell.sv
// pu_msp430_sync_cell: single-bit multi-flop synchroniser into the i_clk domain.
//   i_clk   : destination clock
//   i_rst_n : asynchronous active-low reset, clears every stage
//   i_d     : asynchronous input
//   o_q     : synchronised output, STAGES flops after i_d
module pu_msp430_sync_cell #(
   parameter int STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] r_sync;

   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) r_sync <= '0;
      else r_sync <= {r_sync[STAGES-2:0], i_d};

   assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/pu_msp430_wakeup_gate.sv
// pu_msp430_wakeup_gate: synchronises NCH wakeup requests, qualifies them as level or
// sticky edge, and issues one registered, minimum-width wakeup pulse with the winner's index.
//   mclk, puc_rst_n : clock and asynchronous active-low reset
//   irq_raw         : asynchronous request lines
//   irq_en          : per-channel enable
//   irq_mode        : per-channel mode, 0 = level, 1 = sticky rising edge
//   irq_clr         : write-1 clear of the sticky edge pending bit
//   wkup_ack        : consumer acknowledge
//   pending         : per-channel pending state (not masked by irq_en)
//   wkup_o          : registered wakeup request
//   wkup_id         : lowest-index active channel, captured at assertion
module pu_msp430_wakeup_gate
   import pu_msp430_wakeup_pkg::*;
#(
   parameter  int NCH         = 8,
   parameter  int SYNC_STAGES = 2,
   parameter  int HOLD_CYCLES = 4,
   localparam int IDW         = idw_f(NCH)
) (
   input  logic           mclk,
   input  logic           puc_rst_n,
   input  logic [NCH-1:0] irq_raw,
   input  logic [NCH-1:0] irq_en,
   input  logic [NCH-1:0] irq_mode,
   input  logic [NCH-1:0] irq_clr,
   input  logic           wkup_ack,
   output logic [NCH-1:0] pending,
   output logic           wkup_o,
   output logic [IDW-1:0] wkup_id
);

   localparam int            CW       = $clog2(HOLD_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD_CYCLES - 1);

   if (NCH < NCH_MIN || NCH > NCH_MAX) begin : g_bad_nch
      $error("pu_msp430_wakeup_gate: NCH must be 1..32");
   end
   if (SYNC_STAGES < SYNC_MIN) begin : g_bad_sync
      $error("pu_msp430_wakeup_gate: SYNC_STAGES must be >= 2");
   end
   if (HOLD_CYCLES < HOLD_MIN) begin : g_bad_hold
      $error("pu_msp430_wakeup_gate: HOLD_CYCLES must be >= 1");
   end

   logic [NCH-1:0] w_s, r_s_d, r_mode_d, r_edge, w_edge_nxt, w_act;
   wkup_state_t    r_state, w_state_nxt;
   logic [CW-1:0]  r_cnt;
   logic [IDW-1:0] r_id, w_id;
   logic           r_ack_seen, r_wkup, w_launch;

   for (genvar g = 0; g < NCH; g++) begin : g_sync
      pu_msp430_sync_cell #(.STAGES(SYNC_STAGES)) u_sync (
         .i_clk   (mclk),
         .i_rst_n (puc_rst_n),
         .i_d     (irq_raw[g]),
         .o_q     (w_s[g])
      );
   end

   // A mode change wipes the sticky bit; otherwise a rising edge sets it and takes
   // priority over a simultaneous clear.
   assign w_edge_nxt = ~(irq_mode ^ r_mode_d) & ((irq_mode & w_s & ~r_s_d) | (r_edge & ~irq_clr));
   assign pending    = (irq_mode & r_edge) | (~irq_mode & w_s);
   assign w_act      = pending & irq_en;

   always_ff @(posedge mclk or negedge puc_rst_n)
      if (!puc_rst_n) begin
         r_s_d    <= '0;
         r_mode_d <= '0;
         r_edge   <= '0;
      end else begin
         r_s_d    <= w_s;
         r_mode_d <= irq_mode;
         r_edge   <= w_edge_nxt;
      end

   always_comb begin
      w_id = '0;
      for (int i = NCH - 1; i >= 0; i--)
         if (w_act[i]) w_id = IDW'(i);
   end

   // RELEASE behaves like IDLE for launching: it is already the one guaranteed low
   // cycle, so a pending request may start the next pulse at the following edge.
   always_comb begin
      w_launch    = 1'b0;
      w_state_nxt = r_state;
      case (r_state)
         ASSERT:  w_state_nxt = (r_cnt == '0 && (r_ack_seen || wkup_ack)) ? RELEASE : ASSERT;
         default: begin
            w_launch    = |w_act;
            w_state_nxt = w_launch ? ASSERT : IDLE;
         end
      endcase
   end

   always_ff @(posedge mclk or negedge puc_rst_n)
      if (!puc_rst_n) begin
         r_state    <= IDLE;
         r_wkup     <= 1'b0;
         r_id       <= '0;
         r_cnt      <= '0;
         r_ack_seen <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_wkup  <= (w_state_nxt == ASSERT);
         if (w_launch) begin
            r_id       <= w_id;
            r_cnt      <= CNT_LOAD;
            r_ack_seen <= 1'b0;
         end else if (r_state == ASSERT) begin
            r_cnt      <= (r_cnt == '0) ? r_cnt : r_cnt - CW'(1);
            r_ack_seen <= r_ack_seen | wkup_ack;
         end
      end

   assign wkup_o  = r_wkup;
   assign wkup_id = r_id;

endmodule

// File: tb/tb_pu_msp430_wakeup_gate.sv
// tb_pu_msp430_wakeup_gate: directed and random checks of two gate configurations
// (8ch/2 sync/hold 4 and 1ch/3 sync/hold 1) against a cycle-level reference model.
module tb_pu_msp430_wakeup_gate;

   localparam int S0 = 2, H0 = 4, S1 = 3, H1 = 1;

   logic       mclk = 1'b0;
   logic       rst_n;
   logic [7:0] raw, en, mode, clr;
   logic       ack;
   logic [7:0] pend_a;
   logic       wkup_a;
   logic [2:0] id_a;
   logic [0:0] pend_b;
   logic       wkup_b;
   logic [0:0] id_b;

   int vecs = 0;
   int errs = 0;

   logic [31:0] m_sc[2], m_sp[2], m_st[2], m_pm[2];
   logic [31:0] m_h[2][8];
   bit          m_on[2], m_ak[2];
   int          m_n[2], m_id[2];

   always #5 mclk = ~mclk;

   pu_msp430_wakeup_gate #(.NCH(8), .SYNC_STAGES(S0), .HOLD_CYCLES(H0)) dut_a (
      .mclk(mclk), .puc_rst_n(rst_n), .irq_raw(raw), .irq_en(en), .irq_mode(mode),
      .irq_clr(clr), .wkup_ack(ack), .pending(pend_a), .wkup_o(wkup_a), .wkup_id(id_a)
   );

   pu_msp430_wakeup_gate #(.NCH(1), .SYNC_STAGES(S1), .HOLD_CYCLES(H1)) dut_b (
      .mclk(mclk), .puc_rst_n(rst_n), .irq_raw(raw[0]), .irq_en(en[0]), .irq_mode(mode[0]),
      .irq_clr(clr[0]), .wkup_ack(ack), .pending(pend_b), .wkup_o(wkup_b), .wkup_id(id_b)
   );

   function automatic logic [31:0] msk_of(input int d);
      return d ? 32'h1 : 32'hff;
   endfunction

   function automatic logic [31:0] m_pend(input int d);
      logic [31:0] mo;
      mo = {24'd0, mode};
      return ((mo & m_st[d]) | (~mo & m_sc[d])) & msk_of(d);
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_sc[d] = '0; m_sp[d] = '0; m_st[d] = '0; m_pm[d] = '0;
         for (int j = 0; j < 8; j++) m_h[d][j] = '0;
         m_on[d] = 0; m_ak[d] = 0; m_n[d] = 0; m_id[d] = 0;
      end
   endtask

   // One rising edge of the reference: inputs are the values held just before the edge.
   task automatic model_edge(input int d);
      logic [31:0] mo, cl, act, rise, msk;
      int          hold, sync;
      hold = d ? H1 : H0;
      sync = d ? S1 : S0;
      msk  = msk_of(d);
      mo   = {24'd0, mode};
      cl   = {24'd0, clr};
      act  = m_pend(d) & {24'd0, en};
      rise = m_sc[d] & ~m_sp[d];
      for (int c = 0; c < 32; c++)
         m_st[d][c] = (mo[c] != m_pm[d][c]) ? 1'b0 : (mo[c] && rise[c]) ? 1'b1 : cl[c] ? 1'b0 : m_st[d][c];
      m_st[d] &= msk;
      if (m_on[d]) begin
         m_ak[d] = m_ak[d] | ack;
         if (m_n[d] >= hold && m_ak[d]) m_on[d] = 0;
         else m_n[d]++;
      end else if (act != 0) begin
         m_on[d] = 1; m_n[d] = 1; m_ak[d] = 0;
         for (int c = 31; c >= 0; c--) if (act[c]) m_id[d] = c;
      end
      for (int j = 7; j > 0; j--) m_h[d][j] = m_h[d][j-1];
      m_h[d][0] = {24'd0, raw} & msk;
      m_sp[d]   = m_sc[d];
      m_sc[d]   = m_h[d][sync-1];
      m_pm[d]   = mo & msk;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vecs++;
      assert (got === exp) else begin
         errs++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_all();
      chk("pend_a", {24'd0, pend_a}, m_pend(0));
      chk("wkup_a", 32'(wkup_a), 32'(m_on[0]));
      chk("id_a", 32'(id_a), 32'(m_id[0]));
      chk("pend_b", 32'(pend_b), m_pend(1));
      chk("wkup_b", 32'(wkup_b), 32'(m_on[1]));
      chk("id_b", 32'(id_b), 32'(m_id[1]));
   endtask

   task automatic step();
      @(posedge mclk);
      if (rst_n) begin
         model_edge(0);
         model_edge(1);
      end
      #1;
      check_all();
      @(negedge mclk);
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      chk("rst_wkup_a", 32'(wkup_a), 32'd0);
      chk("rst_pend_a", {24'd0, pend_a}, 32'd0);
      repeat (n) step();
      rst_n = 1'b1;
   endtask

   task automatic wait_hi(output int n);
      n = 0;
      while (!wkup_a && n < 20) begin
         step();
         n++;
      end
      chk("wait_hi", 32'(wkup_a), 32'd1);
   endtask

   task automatic pulse(input int w0, input int ack_at, output int w);
      w = w0;
      for (int i = 0; i < 40; i++) begin
         ack = (w == ack_at);
         step();
         ack = 1'b0;
         if (!wkup_a) break;
         w++;
      end
   endtask

   initial begin
      int n, w;
      rst_n = 1'b0; raw = '0; en = '0; mode = '0; clr = '0; ack = 1'b0;
      model_reset();
      #2;
      check_all();
      chk("por_id_a", 32'(id_a), 32'd0);
      step(); step();
      rst_n = 1'b1;

      // level latency on ch3, then asynchronous reset mid-pulse
      en = 8'hff; raw = 8'h08;
      step(); chk("lat_e1", 32'(wkup_a), 32'd0);
      step(); chk("lat_e2", 32'(wkup_a), 32'd0);
      step(); chk("lat_e3", 32'(wkup_a), 32'd1);
      chk("lat_id3", 32'(id_a), 32'd3);
      raw = '0;
      do_reset(2);

      // sticky edge on ch0, hold/ack widths and low gap, then write-1 clear
      mode = 8'h01; raw = 8'h01;
      step();
      raw = '0;
      wait_hi(n);
      chk("sticky0", 32'(pend_a[0]), 32'd1);
      pulse(1, 1, w);
      chk("hold4", 32'(w), 32'd4);
      step(); chk("gap1", 32'(wkup_a), 32'd1);
      clr = 8'h01;
      step();
      clr = '0;
      chk("clr0", 32'(pend_a[0]), 32'd0);
      pulse(2, 7, w);
      chk("hold7", 32'(w), 32'd7);
      step(); chk("no_relaunch", 32'(wkup_a), 32'd0);

      // priority and id stability
      mode = '0; raw = 8'h24;
      wait_hi(n);
      chk("prio2", 32'(id_a), 32'd2);
      raw = 8'h26;
      step(); chk("id_keep", 32'(id_a), 32'd2);
      pulse(2, 2, w);
      step(); chk("next_up", 32'(wkup_a), 32'd1);
      chk("prio1", 32'(id_a), 32'd1);
      raw = '0;
      pulse(1, 1, w);
      step();

      // enable masking on ch4
      mode = 8'h10; en = 8'hef; raw = 8'h10;
      step();
      raw = '0;
      repeat (6) step();
      chk("mask_wkup", 32'(wkup_a), 32'd0);
      chk("mask_pend4", 32'(pend_a[4]), 32'd1);
      en = 8'hff;
      step(); chk("unmask", 32'(wkup_a), 32'd1);
      clr = 8'h10;
      pulse(1, 1, w);
      clr = '0;
      step();

      // simultaneous set and clear on ch6
      mode = 8'h40; en = 8'hbf; clr = 8'h40; raw = 8'h40;
      step(); step(); step();
      chk("set_wins", 32'(pend_a[6]), 32'd1);
      step();
      chk("clr_next", 32'(pend_a[6]), 32'd0);
      clr = '0; raw = '0; en = 8'hff; mode = '0;
      repeat (3) step();

      // single-channel config: 4-edge latency and period-2 back-to-back pulses
      do_reset(2);
      ack = 1'b1; raw = 8'h01;
      step(); chk("b_lat1", 32'(wkup_b), 32'd0);
      step(); chk("b_lat2", 32'(wkup_b), 32'd0);
      step(); chk("b_lat3", 32'(wkup_b), 32'd0);
      step(); chk("b_lat4", 32'(wkup_b), 32'd1);
      for (int i = 0; i < 6; i++) begin
         step();
         chk("b_period", 32'(wkup_b), 32'(i % 2));
      end
      chk("b_id", 32'(id_b), 32'd0);
      ack = 1'b0; raw = '0;
      repeat (6) step();

      // random traffic
      for (int t = 0; t < 1500; t++) begin
         if ($urandom_range(0, 3) == 0) raw = raw ^ 8'(1 << $urandom_range(0, 7));
         if ($urandom_range(0, 49) == 0) mode = 8'($urandom);
         if ($urandom_range(0, 29) == 0) en = 8'($urandom);
         clr = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'd0;
         ack = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 399) == 0) do_reset(2);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/pu_msp430_wakeup_gate.md
# pu_msp430_wakeup_gate

Parametrised, glitch-free wakeup aggregator for the MSP430 processing unit. Collects NCH asynchronous wakeup/interrupt requests, synchronises each one, and qualifies it per channel as level or sticky edge. It produces a single flop-driven wakeup pulse with a guaranteed minimum width, plus the index of the winning channel. The block replaces ad-hoc combinational wakeup gating: no combinational path exists from any input to `wkup_o`.

## Interface
Parameters:
- `NCH`, 8: number of request channels; legal range 1..32.
- `SYNC_STAGES`, 2: synchroniser depth per channel; must be ≥2.
- `HOLD_CYCLES`, 4: minimum number of cycles `wkup_o` stays high; must be ≥1.

Ports:
- `mclk` in 1: the only clock.
- `puc_rst_n` in 1: asynchronous, active-low reset.
- `irq_raw` in NCH: asynchronous request lines.
- `irq_en` in NCH: per-channel enable, synchronous to `mclk`.
- `irq_mode` in NCH: per-channel mode; 0 = level, 1 = rising-edge (sticky).
- `irq_clr` in NCH: write-1 clear of the sticky edge pending bit.
- `wkup_ack` in 1: consumer acknowledge, single-cycle or held.
- `pending` out NCH: per-channel pending state; not masked by `irq_en`.
- `wkup_o` out 1: registered wakeup request.
- `wkup_id` out IDW: lowest-index active channel, captured at assertion. IDW = max(1, $clog2(NCH)).

## Operation
- Synchroniser: each `irq_raw[i]` passes through SYNC_STAGES flops to give `s[i]`. A further flop gives `s_d[i]` for edge detection.
- Level mode: `pending[i]` = `s[i]` (combinational from the flop output).
- Edge mode:
  - `pending[i]` is a flop, set when `s[i] & ~s_d[i]`.
  - It is cleared when `irq_clr[i]` is high.
  - Simultaneous set and clear: set wins.
- Switching `irq_mode[i]` clears the edge flop for that channel.
- Active vector: `act` = `pending & irq_en`.
- FSM, 3 states:
  - IDLE: `wkup_o`=0. If `act` is non-zero, go to ASSERT. On that transition, capture `wkup_id` = lowest set index of `act`, load `cnt` = HOLD_CYCLES-1, and clear `ack_seen`.
  - ASSERT: `wkup_o`=1.
    - `cnt` decrements to 0 and then holds.
    - `ack_seen` is set by `wkup_ack`.
    - Exit to RELEASE when `cnt`==0 and (`ack_seen` | `wkup_ack`).
    - Changes to `act`, `irq_en` or `irq_mode` during ASSERT do not shorten the pulse and do not change `wkup_id`.
  - RELEASE: `wkup_o`=0 for exactly one cycle (guaranteed low gap), then go to IDLE. In IDLE, `act` is re-evaluated on the next edge.
- `wkup_ack` in IDLE or RELEASE is ignored.
- `wkup_o` and `wkup_id` come directly from flops; glitch-free by construction.

## Timing
- Reset (asynchronous, immediate): all synchroniser flops, `s_d`, edge pending bits, FSM (to IDLE), `cnt`, and `ack_seen` clear to 0.
  - Outputs under reset: `pending`=0, `wkup_o`=0, `wkup_id`=0.
  - Reset during ASSERT drops `wkup_o` immediately. The first possible reassertion is one cycle after `s` becomes valid following release of reset.
- Latency, with `irq_raw` rising and first sampled at edge k:
  - `s` is high after edge k+SYNC_STAGES-1.
  - Level `pending` is high after that same edge.
  - Edge `pending` is high after edge k+SYNC_STAGES.
  - `wkup_o` is high one edge after `act` becomes non-zero.
- Pulse width: `wkup_o` is high for max(HOLD_CYCLES, cycles until ack+1) cycles.
  - Ack present on the first ASSERT cycle with HOLD_CYCLES=1 gives a 1-cycle pulse.
- Back-to-back requests: minimum period HOLD_CYCLES+1 cycles (ASSERT plus RELEASE).
- Edge pulses on `irq_raw` shorter than one `mclk` period may be missed. Level/edge mode is the caller's choice.

## Structure
- Package `pu_msp430_wakeup_pkg`:
  - typedef `wkup_state_t` enum {IDLE, ASSERT, RELEASE}.
  - Localparam function for IDW.
  - Parameter-legality constants.
- Sub-module `pu_msp430_sync_cell`: one channel's SYNC_STAGES-deep synchroniser with asynchronous active-low reset. Instantiated NCH times in a generate loop; synthesis must not retime or ungroup it.
- Top level: edge/pending logic, priority encoder (lowest index wins), FSM, and the hold counter of width $clog2(HOLD_CYCLES+1).
- Elaboration-time assertions reject illegal parameter values.

## Test plan
- Reset during ASSERT: NCH=8, HOLD_CYCLES=4; ch3 level high → `wkup_o` rises 3 edges after first sample. Assert `puc_rst_n`=0 mid-pulse → `wkup_o`=0 immediately with no clock; `pending`=0.
- Hold and ack: ch0 edge mode, 1-cycle high on `irq_raw` → `pending[0]` sticky. `wkup_o` high exactly 4 cycles with ack on cycle 1; with ack on cycle 7, high 7 cycles; then 1 low cycle. `irq_clr[0]` clears `pending[0]` after the next edge.
- Priority and stability: ch5 and ch2 activate on the same cycle → `wkup_id`=2. Ch1 rises mid-ASSERT → `wkup_id` stays 2. After RELEASE, the next pulse reports `wkup_id`=1.
- Enable masking: ch4 edge pending with `irq_en[4]`=0 → `wkup_o` stays 0 and `pending[4]`=1. Setting the enable → `wkup_o` rises 1 edge later.
- Simultaneous set/clear: rising `s[6]` on the same cycle as `irq_clr[6]`=1 → `pending[6]`=1.
- Parameter sweep: NCH=1, SYNC_STAGES=3, HOLD_CYCLES=1 → IDW=1, `wkup_id`=0, latency 4 edges. Back-to-back level request gives a period of 2 cycles.
